dma_rd_engine: RTL and testbench
================================

// Module: dma_rd_engine
// PURPOSE
// - Host-facing read engine behind the peripheral dma_if read signals (rd_go/rd_addr/rd_size/rd_data/empty/rd_en/rd_done).
// - Converts one read job into word-sized host memory read requests.
// - Buffers the in-order responses in an internal FIFO and presents them to the user side as a pop-on-rd_en stream.
// PARAMETERS
// - DATA_WIDTH  32  width of one data word; also the host response width.
// - ADDR_WIDTH  32  word address width.
// - SIZE_WIDTH  16  width of the job length, in words.
// - FIFO_DEPTH  16  response FIFO depth in words; power of 2, >=2.
// PORTS
// - clk            in   1           clock; all logic on rising edge.
// - rst            in   1           synchronous reset, active-high.
// - rd_go          in   1           start-job strobe; sampled only in IDLE or DONE.
// - rd_addr        in   ADDR_WIDTH  first word address; captured with rd_go.
// - rd_size        in   SIZE_WIDTH  job length in words; captured with rd_go.
// - rd_data        out  DATA_WIDTH  FIFO head word; valid while !empty.
// - empty          out  1           FIFO empty.
// - rd_en          in   1           pop FIFO head this cycle.
// - rd_done        out  1           job complete (level).
// - mem_req_valid  out  1           host read request valid.
// - mem_req_addr   out  ADDR_WIDTH  host read word address.
// - mem_req_ready  in   1           host accepts request when valid&&ready.
// - mem_rsp_valid  in   1           host response valid; responses arrive in request order.
// - mem_rsp_data   in   DATA_WIDTH  host response word.
// BEHAVIOUR
// - Reset values: mem_req_valid=0, mem_req_addr=0, empty=1, rd_done=0, rd_data=don't-care.
//   Reset clears the FIFO, counters and FSM from any state; in-flight responses after reset are dropped.
// - FSM states:
//   - IDLE: rd_go -> latch addr/size, go to REQ; if rd_size==0, go to DONE instead.
//   - REQ: issue requests; after the last request is accepted, go to DRAIN.
//   - DRAIN: once all rd_size words have been popped by rd_en, go to DONE.
//   - DONE: rd_done=1; rd_go -> restart exactly as from IDLE.
// - rd_done is cleared on the cycle after rd_go is accepted. rd_go is ignored in REQ and DRAIN.
// - Requests:
//   - k-th request address = latched rd_addr + k, for k = 0..size-1, modulo 2^ADDR_WIDTH (wraps silently).
//   - mem_req_valid is held with a stable address until ready; one request transfers per cycle max.
// - Credit rule: assert mem_req_valid only if outstanding + fifo_count < FIFO_DEPTH, so a response never finds the FIFO full.
//   - outstanding = accepted requests minus received responses.
//   - An overflow would be a design error; the bench asserts it never happens.
// - FIFO:
//   - mem_rsp_valid pushes mem_rsp_data.
//   - rd_en && !empty pops; rd_data shows the new head the next cycle.
//   - Push and pop in the same cycle (including on empty with a push) keep the count consistent.
//   - rd_en while empty is ignored.
//   - First-word latency: push at cycle N -> empty=0 at N+1.
// - Counters are sized SIZE_WIDTH+1 so the maximum size does not alias to 0.
// CONFIGURATION
// - DMA_RD_PERF_EN defined: adds outputs perf_cycles[31:0] and perf_words[31:0].
//   - perf_cycles counts cycles in REQ or DRAIN; perf_words counts words popped.
//   - Both clear on accepted rd_go and on rst, and saturate at all-ones.
// - DMA_RD_PERF_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.
// TESTING
// - Ready always 1, 1-cycle response, rd_go addr=0x100 size=4, rd_en held 1
//   -> requests 0x100..0x103 back-to-back; data popped in order; rd_done=1 after the 4th pop.
// - size=0 -> no mem_req_valid; rd_done=1 one cycle after rd_go.
// - size=40, rd_en held 0 until stall -> at most 16 outstanding+buffered, mem_req_valid drops;
//   then drain with rd_en=1 -> all 40 words in order, no loss.
// - Random mem_req_ready backpressure
//   -> mem_req_addr stable while valid&&!ready; addr=0xFFFFFFFE size=4 wraps to 0x0,0x1.
// - rst asserted in REQ with 3 responses pending -> empty=1, rd_done=0, mem_req_valid=0 next cycle;
//   a new job then runs cleanly.
// - rd_go during DRAIN ignored; with DMA_RD_PERF_EN, a 4-word job with no stalls -> perf_words=4.

Source files
------------

// File: rtl/dma_rd_engine.sv
// Host read engine: turns one read job into word requests, buffers in-order responses in a FIFO
// and serves them as a pop-on-rd_en stream. Optional perf counters under DMA_RD_PERF_EN.
module dma_rd_engine #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int SIZE_WIDTH = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_go,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [SIZE_WIDTH-1:0] rd_size,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  empty,
   input  logic                  rd_en,
   output logic                  rd_done,
   output logic                  mem_req_valid,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_req_ready,
   input  logic                  mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] mem_rsp_data,
`ifdef DMA_RD_PERF_EN
   output logic [31:0]           perf_cycles,
   output logic [31:0]           perf_words,
`endif
   output logic [1:0]            state_dbg
);

   // Handshake: a request transfers on a cycle where mem_req_valid && mem_req_ready are both
   // high; valid never drops and the address never changes while waiting for ready.
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int NW = SIZE_WIDTH + 1;
   localparam logic [CW:0] CREDIT_MAX = (CW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                state_q, state_n;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [NW-1:0]         size_q, req_cnt, pop_cnt;
   logic [CW-1:0]         outstanding, fifo_count;
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic                  go_acc, req_fire, push, pop, credit_ok, last_req, last_pop;

   assign go_acc   = rd_go && (state_q == S_IDLE || state_q == S_DONE);
   assign req_fire = mem_req_valid && mem_req_ready;
   // Responses with nothing outstanding are leftovers from before a reset and are dropped.
   assign push     = mem_rsp_valid && (outstanding != '0);
   assign pop      = rd_en && !empty;
   assign empty    = (fifo_count == '0);
   assign rd_data  = fifo_mem[rd_ptr];

   // Reserve FIFO space for every request in flight so a response always has room.
   assign credit_ok     = ({1'b0, outstanding} + {1'b0, fifo_count}) < CREDIT_MAX;
   assign last_req      = (req_cnt + NW'(1)) == size_q;
   assign last_pop      = (pop_cnt == size_q) || (pop && ((pop_cnt + NW'(1)) == size_q));
   assign mem_req_valid = (state_q == S_REQ) && credit_ok && (req_cnt < size_q);
   assign mem_req_addr  = addr_q + ADDR_WIDTH'(req_cnt);
   assign rd_done       = (state_q == S_DONE);
   assign state_dbg     = state_q;

   always_comb begin
      state_n = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (rd_go) state_n = (rd_size == '0) ? S_DONE : S_REQ;
         end
         S_REQ: begin
            if (req_fire && last_req) state_n = S_DRAIN;
         end
         S_DRAIN: begin
            if (last_pop) state_n = S_DONE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         size_q      <= '0;
         req_cnt     <= '0;
         pop_cnt     <= '0;
         outstanding <= '0;
         fifo_count  <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         state_q <= state_n;
         if (go_acc) begin
            addr_q  <= rd_addr;
            size_q  <= {1'b0, rd_size};
            req_cnt <= '0;
            pop_cnt <= '0;
         end else begin
            if (req_fire) req_cnt <= req_cnt + NW'(1);
            if (pop)      pop_cnt <= pop_cnt + NW'(1);
         end
         case ({req_fire, push})
            2'b10:   outstanding <= outstanding + CW'(1);
            2'b01:   outstanding <= outstanding - CW'(1);
            default: outstanding <= outstanding;
         endcase
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= mem_rsp_data;
   end

`ifdef DMA_RD_PERF_EN
   always_ff @(posedge clk) begin
      if (rst || go_acc) begin
         perf_cycles <= '0;
         perf_words  <= '0;
      end else begin
         if ((state_q == S_REQ || state_q == S_DRAIN) && perf_cycles != '1)
            perf_cycles <= perf_cycles + 32'd1;
         if (pop && perf_words != '1)
            perf_words <= perf_words + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dma_rd_engine.sv
// Directed bench for dma_rd_engine: a reactive host model with 1-cycle responses, a data and
// address scoreboard, and a linear sequence of job scenarios.
module tb_dma_rd_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_go = 1'b0;
   logic [31:0] rd_addr = '0;
   logic [15:0] rd_size = '0;
   logic [31:0] rd_data;
   logic        empty;
   logic        rd_en = 1'b0;
   logic        rd_done;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready = 1'b1;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data = '0;
   logic [1:0]  state_dbg;
`ifdef DMA_RD_PERF_EN
   logic [31:0] perf_cycles;
   logic [31:0] perf_words;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_addr_q[$];
   int          fired = 0;
   int          pops = 0;
   int          rsp_seen = 0;
   bit          pop_en = 1'b0;
   bit          rand_rdy = 1'b0;
   logic        pend_v = 1'b0;
   logic [31:0] pend_d = '0;
   bit          stall_prev = 1'b0;
   logic [31:0] stall_addr = '0;

   dma_rd_engine dut (
      .clk           (clk),
      .rst           (rst),
      .rd_go         (rd_go),
      .rd_addr       (rd_addr),
      .rd_size       (rd_size),
      .rd_data       (rd_data),
      .empty         (empty),
      .rd_en         (rd_en),
      .rd_done       (rd_done),
      .mem_req_valid (mem_req_valid),
      .mem_req_addr  (mem_req_addr),
      .mem_req_ready (mem_req_ready),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
`ifdef DMA_RD_PERF_EN
      .perf_cycles   (perf_cycles),
      .perf_words    (perf_words),
`endif
      .state_dbg     (state_dbg)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [31:0] a);
      return a ^ 32'hC3C3_0F0F;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic start_job(input logic [31:0] a, input logic [15:0] s);
      for (int k = 0; k < int'(s); k++) begin
         exp_addr_q.push_back(a + 32'(k));
         exp_q.push_back(model(a + 32'(k)));
      end
      fired    = 0;
      pops     = 0;
      rsp_seen = 0;
      rd_go    = 1'b1;
      rd_addr  = a;
      rd_size  = s;
      tick();
      rd_go    = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (!rd_done && n < budget) begin
         tick();
         n++;
      end
      check(tag, {31'd0, rd_done}, 32'd1);
   endtask

   // Host model and output monitor; everything is sampled and driven on the falling edge.
   always @(negedge clk) begin
      mem_rsp_valid = pend_v;
      mem_rsp_data  = pend_d;
      if (pend_v) begin
         check("fifo_room", {31'd0, (rsp_seen - pops) < 16}, 32'd1);
         rsp_seen++;
      end
      rd_en = pop_en;
      if (rd_en && !empty) begin
         if (exp_q.size() == 0) check("data_extra", 32'(exp_q.size()), 32'd1);
         else check("rd_data", rd_data, exp_q.pop_front());
         pops++;
      end
      if (stall_prev && !rst) begin
         check("req_hold_valid", {31'd0, mem_req_valid}, 32'd1);
         check("req_hold_addr", mem_req_addr, stall_addr);
      end
      mem_req_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      pend_v = mem_req_valid && mem_req_ready;
      pend_d = model(mem_req_addr);
      if (pend_v) begin
         fired++;
         if (exp_addr_q.size() == 0) check("addr_extra", 32'(exp_addr_q.size()), 32'd1);
         else check("req_addr", mem_req_addr, exp_addr_q.pop_front());
      end
      stall_prev = mem_req_valid && !mem_req_ready;
      stall_addr = mem_req_addr;
   end

   initial begin
      int n;
      // reset values
      tick();
      tick();
      check("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
      check("rst_req_addr", mem_req_addr, 32'd0);
      check("rst_empty", {31'd0, empty}, 32'd1);
      check("rst_done", {31'd0, rd_done}, 32'd0);
      rst = 1'b0;
      tick();

      // zero-length job
      pop_en = 1'b1;
      start_job(32'h80, 16'd0);
      check("z_done", {31'd0, rd_done}, 32'd1);
      check("z_req_valid", {31'd0, mem_req_valid}, 32'd0);
      repeat (3) tick();
      check("z_fired", 32'(fired), 32'd0);

      // basic 4-word job, ready always high
      start_job(32'h100, 16'd4);
      check("b_done_clr", {31'd0, rd_done}, 32'd0);
      wait_done("b_done", 40);
      check("b_pops", 32'(pops), 32'd4);
      check("b_exp_left", 32'(exp_q.size()), 32'd0);
      check("b_addr_left", 32'(exp_addr_q.size()), 32'd0);
`ifdef DMA_RD_PERF_EN
      check("perf_words", perf_words, 32'd4);
`endif

      // credit stall: 40 words with no pops
      pop_en = 1'b0;
      start_job(32'h1000, 16'd40);
      repeat (40) tick();
      check("s_req_valid", {31'd0, mem_req_valid}, 32'd0);
      check("s_fired", 32'(fired), 32'd16);
      check("s_empty", {31'd0, empty}, 32'd0);
      pop_en = 1'b1;
      wait_done("s_done", 400);
      check("s_pops", 32'(pops), 32'd40);
      check("s_exp_left", 32'(exp_q.size()), 32'd0);

      // random backpressure with address wrap
      rand_rdy = 1'b1;
      start_job(32'hFFFF_FFFE, 16'd4);
      wait_done("w_done", 200);
      check("w_pops", 32'(pops), 32'd4);
      check("w_addr_left", 32'(exp_addr_q.size()), 32'd0);
      rand_rdy = 1'b0;

      // rd_go during DRAIN is ignored
      pop_en = 1'b0;
      start_job(32'h200, 16'd8);
      n = 0;
      while (fired < 8 && n < 50) begin
         tick();
         n++;
      end
      check("d_fired", 32'(fired), 32'd8);
      rd_go   = 1'b1;
      rd_addr = 32'h500;
      rd_size = 16'd2;
      tick();
      rd_go = 1'b0;
      repeat (3) tick();
      check("d_no_new_req", 32'(fired), 32'd8);
      check("d_not_done", {31'd0, rd_done}, 32'd0);
      pop_en = 1'b1;
      wait_done("d_done", 100);
      check("d_pops", 32'(pops), 32'd8);
      check("d_exp_left", 32'(exp_q.size()), 32'd0);

      // reset mid-job with responses in flight, then a clean job
      pop_en = 1'b0;
      start_job(32'h300, 16'd8);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check("r_empty", {31'd0, empty}, 32'd1);
      check("r_done", {31'd0, rd_done}, 32'd0);
      check("r_req_valid", {31'd0, mem_req_valid}, 32'd0);
      rst = 1'b0;
      repeat (3) tick();
      check("r_stray_dropped", {31'd0, empty}, 32'd1);
      exp_q.delete();
      exp_addr_q.delete();
      pop_en = 1'b1;
      start_job(32'h400, 16'd3);
      wait_done("r_done2", 60);
      check("r_pops", 32'(pops), 32'd3);
      check("r_exp_left", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
